// File: rtl/sdram_arb2.sv
// Two-port Avalon-MM round-robin arbiter in front of a single SDRAM master.
// Read responses are steered back to their requester through a source-ID FIFO.
module sdram_arb2 #(
    parameter int MAX_PENDING = 4,
    parameter int PW          = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] r0_address,
    input  logic        r0_read,
    input  logic        r0_write,
    input  logic [31:0] r0_writedata,
    output logic        r0_waitrequest,
    output logic [31:0] r0_readdata,
    output logic        r0_readdatavalid,
    input  logic [31:0] r1_address,
    input  logic        r1_read,
    input  logic        r1_write,
    input  logic [31:0] r1_writedata,
    output logic        r1_waitrequest,
    output logic [31:0] r1_readdata,
    output logic        r1_readdatavalid,
    input  logic        master_waitrequest,
    output logic [31:0] master_address,
    output logic        master_read,
    output logic        master_write,
    output logic [31:0] master_writedata,
    input  logic [31:0] master_readdata,
    input  logic        master_readdatavalid,
    output logic [PW-1:0] pending_count,
    output logic        err_stray
);

    localparam int AW = (MAX_PENDING > 2) ? $clog2(MAX_PENDING) : 1;
    localparam logic [PW-1:0] MAX_CNT = PW'(MAX_PENDING);

    typedef enum logic {
        S_IDLE,
        S_LOCK
    } state_t;

    state_t          state_q, state_d;
    logic            owner_q, owner_d;
    logic            last_q, last_d;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PW-1:0]   count_q;
    logic            err_q;
    logic            id_mem [MAX_PENDING];

    logic            not_full;
    logic            elig0, elig1;
    logic            grant;
    logic            owner;
    logic            sel_read, sel_write;
    logic            accept;
    logic            push, pop;
    logic            head_id;

    // Full is judged on the registered count only; a same-cycle pop does not help.
    assign not_full = (count_q < MAX_CNT);
    assign elig0    = r0_write | (r0_read & not_full);
    assign elig1    = r1_write | (r1_read & not_full);

    always_comb begin
        grant     = 1'b0;
        owner     = owner_q;
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        sel_read  = 1'b0;
        sel_write = 1'b0;
        accept    = 1'b0;

        // Holding reset forces every command output idle immediately.
        if (!rst_n) begin
            grant = 1'b0;
        end else if (state_q == S_LOCK) begin
            grant = 1'b1;
            owner = owner_q;
        end else if (elig0 && elig1) begin
            grant = 1'b1;
            owner = ~last_q;
        end else if (elig0) begin
            grant = 1'b1;
            owner = 1'b0;
        end else if (elig1) begin
            grant = 1'b1;
            owner = 1'b1;
        end

        sel_read  = grant & (owner ? r1_read  : r0_read);
        sel_write = grant & (owner ? r1_write : r0_write);
        accept    = (sel_read | sel_write) & ~master_waitrequest;

        case (state_q)
            S_IDLE: begin
                if ((sel_read | sel_write) && master_waitrequest) begin
                    state_d = S_LOCK;
                    owner_d = owner;
                end
            end
            S_LOCK: begin
                if (accept) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            last_d = owner;
        end
    end

    assign master_read      = sel_read;
    assign master_write     = sel_write;
    assign master_address   = owner ? r1_address   : r0_address;
    assign master_writedata = owner ? r1_writedata : r0_writedata;

    assign r0_waitrequest = ~(grant & ~owner) | master_waitrequest;
    assign r1_waitrequest = ~(grant &  owner) | master_waitrequest;

    assign push    = sel_read & ~master_waitrequest;
    assign pop     = master_readdatavalid & (count_q != '0);
    assign head_id = id_mem[rd_ptr_q];

    assign r0_readdata      = master_readdata;
    assign r1_readdata      = master_readdata;
    assign r0_readdatavalid = pop & ~head_id;
    assign r1_readdatavalid = pop &  head_id;

    assign pending_count = count_q;
    assign err_stray     = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + PW'(1);
                2'b01:   count_q <= count_q - PW'(1);
                default: count_q <= count_q;
            endcase
            if (master_readdatavalid && (count_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // ID storage carries no reset; validity is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr_q] <= owner;
        end
    end

endmodule
